// File: rtl/gcbp_line_packer.sv
// Converts a raster luma stream into Gray-coded bit-plane bits and packs each
// horizontal sub-image window of a line into one word with a one-cycle strobe.
module gcbp_line_packer #(
    parameter int C_LUMA_BITS  = 8,
    parameter int C_BIT_PLANE  = 4,
    parameter int C_LINE_WIDTH = 640,
    parameter int C_SUBIMAGE_W = 128,
    parameter int C_NUM_HORI   = 4,
    parameter int C_HORI_EDGE  = 25,
    parameter int C_HORI_GAP   = 26,
    localparam int IDX_W       = (C_NUM_HORI > 1) ? $clog2(C_NUM_HORI) : 1
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_line_start,
    input  logic [C_LUMA_BITS-1:0]  i_luma_data,
    input  logic                    i_luma_data_valid,
    output logic [C_SUBIMAGE_W-1:0] o_gcbp_line,
    output logic                    o_gcbp_line_valid,
    output logic [IDX_W-1:0]        o_hori_subimage_cnt,
    output logic                    o_line_overrun
);

    localparam int X_W       = $clog2(C_LINE_WIDTH + 1);
    localparam int SEG_MAX_A = (C_SUBIMAGE_W > C_HORI_EDGE) ? C_SUBIMAGE_W : C_HORI_EDGE;
    localparam int SEG_MAX   = (SEG_MAX_A > C_HORI_GAP) ? SEG_MAX_A : C_HORI_GAP;
    localparam int CNT_W     = $clog2(SEG_MAX + 1);

    // Segment counters compare against length-1, so every segment needs at least one pixel.
    if (C_HORI_EDGE < 1 || C_HORI_GAP < 1 || C_SUBIMAGE_W < 2 || C_NUM_HORI < 1 ||
        C_BIT_PLANE >= C_LUMA_BITS ||
        2 * C_HORI_EDGE + (C_NUM_HORI - 1) * C_HORI_GAP + C_NUM_HORI * C_SUBIMAGE_W != C_LINE_WIDTH)
    begin : g_bad_params
        $error("gcbp_line_packer: inconsistent line geometry parameters");
    end

    typedef enum logic [1:0] {
        S_EDGE,
        S_CAPTURE,
        S_GAP,
        S_TAIL
    } state_t;

    state_t                  state;
    logic [X_W-1:0]          x;
    logic [CNT_W-1:0]        seg_cnt;
    logic [IDX_W-1:0]        sub_idx;
    logic [C_SUBIMAGE_W-1:0] shreg;

    state_t                  cur_state;
    logic [X_W-1:0]          cur_x;
    logic [CNT_W-1:0]        cur_cnt;
    logic [IDX_W-1:0]        cur_sub;
    logic [C_SUBIMAGE_W-1:0] cur_shreg;
    logic [C_SUBIMAGE_W-1:0] shifted;
    logic [C_LUMA_BITS-1:0]  gray;
    logic                    plane_bit;
    logic                    unused_bits;

    always_comb begin
        gray        = i_luma_data ^ (i_luma_data >> 1);
        plane_bit   = gray[C_BIT_PLANE];
        unused_bits = ^{gray, cur_shreg[C_SUBIMAGE_W-1]};
    end

    // A line start restarts the line before the same-cycle pixel is processed,
    // so that pixel is handled as x=0 against a fresh context.
    always_comb begin
        cur_state = state;
        cur_x     = x;
        cur_cnt   = seg_cnt;
        cur_sub   = sub_idx;
        cur_shreg = shreg;
        if (i_line_start) begin
            cur_state = S_EDGE;
            cur_x     = '0;
            cur_cnt   = '0;
            cur_sub   = '0;
            cur_shreg = '0;
        end
        shifted = {cur_shreg[C_SUBIMAGE_W-2:0], plane_bit};
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state               <= S_EDGE;
            x                   <= '0;
            seg_cnt             <= '0;
            sub_idx             <= '0;
            shreg               <= '0;
            o_gcbp_line         <= '0;
            o_gcbp_line_valid   <= 1'b0;
            o_hori_subimage_cnt <= '0;
            o_line_overrun      <= 1'b0;
        end else begin
            o_gcbp_line_valid <= 1'b0;
            state             <= cur_state;
            x                 <= cur_x;
            seg_cnt           <= cur_cnt;
            sub_idx           <= cur_sub;
            shreg             <= cur_shreg;
            if (i_line_start) begin
                o_line_overrun <= 1'b0;
            end
            if (i_luma_data_valid) begin
                if (cur_x == X_W'(C_LINE_WIDTH)) begin
                    o_line_overrun <= 1'b1;
                end else begin
                    x <= cur_x + X_W'(1);
                    case (cur_state)
                        S_EDGE: begin
                            if (cur_cnt == CNT_W'(C_HORI_EDGE - 1)) begin
                                state   <= S_CAPTURE;
                                seg_cnt <= '0;
                            end else begin
                                seg_cnt <= cur_cnt + CNT_W'(1);
                            end
                        end
                        S_CAPTURE: begin
                            shreg <= shifted;
                            if (cur_cnt == CNT_W'(C_SUBIMAGE_W - 1)) begin
                                o_gcbp_line         <= shifted;
                                o_gcbp_line_valid   <= 1'b1;
                                o_hori_subimage_cnt <= cur_sub;
                                seg_cnt             <= '0;
                                state <= (cur_sub == IDX_W'(C_NUM_HORI - 1)) ? S_TAIL : S_GAP;
                            end else begin
                                seg_cnt <= cur_cnt + CNT_W'(1);
                            end
                        end
                        S_GAP: begin
                            if (cur_cnt == CNT_W'(C_HORI_GAP - 1)) begin
                                state   <= S_CAPTURE;
                                seg_cnt <= '0;
                                sub_idx <= cur_sub + IDX_W'(1);
                            end else begin
                                seg_cnt <= cur_cnt + CNT_W'(1);
                            end
                        end
                        S_TAIL: begin
                        end
                        default: state <= S_EDGE;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_gcbp_line_packer.sv
// Randomized bench for gcbp_line_packer against a position-based line model.
module tb_gcbp_line_packer;

    localparam int LINE_W = 640;
    localparam int EDGE   = 25;
    localparam int SUBW   = 128;
    localparam int PITCH  = 154;
    localparam int NHORI  = 4;

    logic         i_clk = 1'b0;
    logic         i_reset;
    logic         i_line_start;
    logic [7:0]   i_luma_data;
    logic         i_luma_data_valid;
    logic [127:0] o_gcbp_line;
    logic         o_gcbp_line_valid;
    logic [1:0]   o_hori_subimage_cnt;
    logic         o_line_overrun;

    gcbp_line_packer dut (
        .i_clk               (i_clk),
        .i_reset             (i_reset),
        .i_line_start        (i_line_start),
        .i_luma_data         (i_luma_data),
        .i_luma_data_valid   (i_luma_data_valid),
        .o_gcbp_line         (o_gcbp_line),
        .o_gcbp_line_valid   (o_gcbp_line_valid),
        .o_hori_subimage_cnt (o_hori_subimage_cnt),
        .o_line_overrun      (o_line_overrun)
    );

    always #5 i_clk = ~i_clk;

    int checks   = 0;
    int failures = 0;
    int strobes  = 0;

    // Reference model state
    int           mx;
    logic         movr;
    logic [127:0] mword;
    logic [1:0]   midx;
    logic [7:0]   line_buf [LINE_W];
    logic [7:0]   rnd_line [LINE_W];

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic gbit(input logic [7:0] y);
        logic [7:0] g;
        g = y ^ (y >> 1);
        return g[4];
    endfunction

    task automatic model_reset();
        mx    = 0;
        movr  = 1'b0;
        mword = '0;
        midx  = '0;
    endtask

    task automatic step(input logic start, input logic valid, input logic [7:0] y);
        logic exp_valid;
        int   rel;
        int   base;
        i_line_start      = start;
        i_luma_data_valid = valid;
        i_luma_data       = y;
        @(posedge i_clk);
        exp_valid = 1'b0;
        if (start) begin
            mx   = 0;
            movr = 1'b0;
        end
        if (valid) begin
            if (mx == LINE_W) begin
                movr = 1'b1;
            end else begin
                line_buf[mx] = y;
                rel = mx - EDGE;
                if (rel >= 0 && (rel % PITCH) == SUBW - 1 && (rel / PITCH) < NHORI) begin
                    base = EDGE + (rel / PITCH) * PITCH;
                    for (int i = 0; i < SUBW; i++) mword[127 - i] = gbit(line_buf[base + i]);
                    midx      = 2'(rel / PITCH);
                    exp_valid = 1'b1;
                end
                mx++;
            end
        end
        #1;
        check_eq("valid", 128'(o_gcbp_line_valid), 128'(exp_valid));
        check_eq("word", o_gcbp_line, mword);
        check_eq("index", 128'(o_hori_subimage_cnt), 128'(midx));
        check_eq("overrun", 128'(o_line_overrun), 128'(movr));
        if (o_gcbp_line_valid) strobes++;
    endtask

    task automatic reset_cycles(input int n);
        i_reset           = 1'b1;
        i_line_start      = 1'b0;
        i_luma_data_valid = 1'b0;
        i_luma_data       = 8'($urandom);
        repeat (n) @(posedge i_clk);
        #1;
        model_reset();
        check_eq("rst_valid", 128'(o_gcbp_line_valid), 128'(0));
        check_eq("rst_word", o_gcbp_line, 128'(0));
        check_eq("rst_index", 128'(o_hori_subimage_cnt), 128'(0));
        check_eq("rst_overrun", 128'(o_line_overrun), 128'(0));
        i_reset = 1'b0;
    endtask

    // mode 0: constant cval, 1: ramp y=x[7:0], 2: stored random line
    task automatic drive_line(input int n, input int mode, input logic [7:0] cval,
                              input int stall_pct, input bit with_start);
        logic [7:0] y;
        int stalls;
        for (int i = 0; i < n; i++) begin
            case (mode)
                0:       y = cval;
                1:       y = 8'(i);
                default: y = rnd_line[i % LINE_W];
            endcase
            stalls = 0;
            while (stall_pct > 0 && stalls < 8 && int'($urandom_range(99)) < stall_pct) begin
                step(1'b0, 1'b0, 8'($urandom));
                stalls++;
            end
            step(with_start && i == 0, 1'b1, y);
        end
    endtask

    initial begin
        i_reset           = 1'b0;
        i_line_start      = 1'b0;
        i_luma_data_valid = 1'b0;
        i_luma_data       = '0;
        for (int i = 0; i < LINE_W; i++) rnd_line[i] = 8'($urandom);

        reset_cycles(2);

        // Constant 0x18: bit-plane 4 is one everywhere
        strobes = 0;
        drive_line(LINE_W, 0, 8'h18, 0, 1'b1);
        check_eq("ones_strobes", 128'(strobes), 128'(4));
        check_eq("ones_word", o_gcbp_line, {128{1'b1}});
        check_eq("ones_index", 128'(o_hori_subimage_cnt), 128'(3));

        // Constant 0x80: bit-plane 4 is zero everywhere
        strobes = 0;
        drive_line(LINE_W, 0, 8'h80, 0, 1'b1);
        check_eq("zeros_strobes", 128'(strobes), 128'(4));
        check_eq("zeros_word", o_gcbp_line, 128'(0));

        // Ramp
        strobes = 0;
        drive_line(LINE_W, 1, 8'h00, 0, 1'b1);
        check_eq("ramp_strobes", 128'(strobes), 128'(4));

        // Random line gap-free, then the same line with ~50% valid stalls
        strobes = 0;
        drive_line(LINE_W, 2, 8'h00, 0, 1'b1);
        check_eq("rand_strobes", 128'(strobes), 128'(4));
        strobes = 0;
        drive_line(LINE_W, 2, 8'h00, 50, 1'b1);
        check_eq("stall_strobes", 128'(strobes), 128'(4));

        // Line aborted at x=200 by a start carried on the next pixel
        strobes = 0;
        drive_line(200, 2, 8'h00, 20, 1'b1);
        check_eq("short_strobes", 128'(strobes), 128'(1));
        strobes = 0;
        drive_line(LINE_W, 1, 8'h00, 0, 1'b1);
        check_eq("after_short_strobes", 128'(strobes), 128'(4));

        // Abort via a start strobe on an idle cycle
        strobes = 0;
        drive_line(350, 2, 8'h00, 0, 1'b1);
        step(1'b1, 1'b0, 8'h00);
        drive_line(LINE_W, 2, 8'h00, 30, 1'b0);
        check_eq("idle_start_strobes", 128'(strobes), 128'(6));

        // Reset at x=400
        strobes = 0;
        drive_line(400, 2, 8'h00, 0, 1'b1);
        check_eq("pre_reset_strobes", 128'(strobes), 128'(2));
        reset_cycles(1);
        strobes = 0;
        drive_line(LINE_W, 2, 8'h00, 0, 1'b1);
        check_eq("post_reset_strobes", 128'(strobes), 128'(4));

        // Overrun: 645 pixels with no restart
        strobes = 0;
        drive_line(LINE_W, 0, 8'h18, 0, 1'b1);
        check_eq("ovr_before", 128'(o_line_overrun), 128'(0));
        step(1'b0, 1'b1, 8'h18);
        check_eq("ovr_after_641", 128'(o_line_overrun), 128'(1));
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'($urandom));
        check_eq("ovr_strobes", 128'(strobes), 128'(4));
        step(1'b1, 1'b0, 8'h00);
        check_eq("ovr_cleared", 128'(o_line_overrun), 128'(0));
        strobes = 0;
        drive_line(LINE_W, 2, 8'h00, 10, 1'b0);
        check_eq("after_ovr_strobes", 128'(strobes), 128'(4));

        step(1'b0, 1'b0, 8'h00);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
